// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative 32-step multiply/divide unit holding the MIPS
// HI/LO registers. MULT/MULTU use shift-add, DIV/DIVU use restoring
// shift-subtract on magnitudes; signs are reapplied in a final FIX cycle.
// MTHI/MTLO and divide-by-zero complete at the accepting edge.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam int         CW      = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, nextState;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi, accLo, operandB;
  logic             isDiv, negRes, negRem;

  logic             isMulOp, isDivOp, isSigned;
  logic             startIter, startMove, startZero;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic             divFits;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0] quotFix, remFix;

  // Request decode, operand magnitudes and per-step arithmetic
  always_comb begin
    isMulOp   = Start && (Op == OpMult || Op == OpMultu);
    isDivOp   = Start && (Op == OpDiv || Op == OpDivu);
    isSigned  = ~Op[0];
    startIter = (state == IDLE) && (isMulOp || (isDivOp && B != '0));
    startMove = (state == IDLE) && Start && (Op == OpMthi || Op == OpMtlo);
    startZero = (state == IDLE) && isDivOp && (B == '0);
    absA      = (isSigned && A[WIDTH-1]) ? -A : A;
    absB      = (isSigned && B[WIDTH-1]) ? -B : B;
    mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operandB} : '0);
    divShift  = {accHi, accLo[WIDTH-1]};
    divDiff   = divShift - {1'b0, operandB};
    divFits   = ~divDiff[WIDTH];
    prodFix   = negRes ? -{accHi, accLo} : {accHi, accLo};
    quotFix   = negRes ? -accLo : accLo;
    remFix    = negRem ? -accHi : accHi;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state: WIDTH RUN steps, then one FIX cycle
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startIter) nextState = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs derived from state
  always_comb begin
    Busy = (state != IDLE);
  end

  // Datapath: operand capture, iteration, sign fix-up and HI/LO writeback
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count     <= '0;
      accHi     <= '0;
      accLo     <= '0;
      operandB  <= '0;
      isDiv     <= 1'b0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HiOut     <= '0;
      LoOut     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (startIter) begin
            accHi     <= '0;
            accLo     <= absA;
            operandB  <= absB;
            isDiv     <= Op[1];
            negRes    <= isSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
            negRem    <= isSigned && Op[1] && A[WIDTH-1];
            count     <= '0;
            DivByZero <= 1'b0;
          end else if (startMove) begin
            if (Op[0]) LoOut <= A;
            else       HiOut <= A;
            DivByZero <= 1'b0;
            Done      <= 1'b1;
          end else if (startZero) begin
            DivByZero <= 1'b1;
            Done      <= 1'b1;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (isDiv) begin
            accHi <= divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], divFits};
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (isDiv) begin
            LoOut <= quotFix;
            HiOut <= remFix;
          end else begin
            {HiOut, LoOut} <= prodFix;
          end
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and randomized checks of hilo_muldiv_unit
// against an arithmetic reference model of HI/LO/DivByZero.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] HiOut, LoOut;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expHi, expLo;
  logic        expDz;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HiOut(HiOut), .LoOut(LoOut)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_hi"}, HiOut, expHi);
    check({tag, "_lo"}, LoOut, expLo);
    check({tag, "_dz"}, {31'b0, DivByZero}, {31'b0, expDz});
  endtask

  // Architectural effect of one accepted request, from plain arithmetic
  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sq, sr;
    longint unsigned up;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        expHi = sp[63:32]; expLo = sp[31:0]; expDz = 1'b0;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        expHi = up[63:32]; expLo = up[31:0]; expDz = 1'b0;
      end
      3'd2: begin
        if (b == 0) expDz = 1'b1;
        else begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          expLo = sq[31:0]; expHi = sr[31:0]; expDz = 1'b0;
        end
      end
      3'd3: begin
        if (b == 0) expDz = 1'b1;
        else begin
          expLo = a / b; expHi = a % b; expDz = 1'b0;
        end
      end
      3'd4: begin expHi = a; expDz = 1'b0; end
      3'd5: begin expLo = a; expDz = 1'b0; end
      default: ;
    endcase
  endtask

  // Present a request at the current negedge; scramble inputs after acceptance
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  // Wait for Done, optionally injecting an MTLO request mid-run
  task automatic waitDone(input int injectAt, output int cycles, output int busyCnt);
    cycles = 0; busyCnt = 0;
    while (cycles < 100) begin
      @(negedge Clk);
      cycles++;
      Start = 1'b0;
      if (Busy) busyCnt++;
      if (Done) break;
      if (cycles == injectAt) begin
        Start = 1'b1; Op = 3'b101; A = 32'h0000DEAD;
      end
    end
    check("done_seen", {31'b0, Done}, 32'd1);
  endtask

  // One complete request: issue, model, wait and compare
  task automatic doOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int   cycles, busyCnt;
    logic iter;
    iter = (op <= 3'd1) || ((op == 3'd2 || op == 3'd3) && b != 0);
    applyStimulus(op, a, b);
    modelOp(op, a, b);
    if (op >= 3'd6) begin
      @(negedge Clk);
      check({tag, "_nodone"}, {31'b0, Done}, 32'd0);
      check({tag, "_nobusy"}, {31'b0, Busy}, 32'd0);
    end else if (iter) begin
      waitDone(-1, cycles, busyCnt);
      check({tag, "_latency"}, cycles, 32'd34);
      check({tag, "_busycycles"}, busyCnt, 32'd33);
    end else begin
      @(negedge Clk);
      check({tag, "_done"}, {31'b0, Done}, 32'd1);
      check({tag, "_nobusy"}, {31'b0, Busy}, 32'd0);
    end
    checkOutput(tag);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h80000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Directed sequence followed by randomized requests
  initial begin
    int          cycles, busyCnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    Reset = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    expHi = '0; expLo = '0; expDz = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    checkOutput("reset");
    Reset = 1'b1;
    @(negedge Clk);

    doOp("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi_const", HiOut, 32'hFFFFFFFE);
    check("multu_max_lo_const", LoOut, 32'h00000001);
    @(negedge Clk);
    check("multu_done_pulse", {31'b0, Done}, 32'd0);

    doOp("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000005);
    check("mult_neg_lo_const", LoOut, 32'hFFFFFFF1);

    doOp("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    check("div_neg_lo_const", LoOut, 32'hFFFFFFFD);
    doOp("divu_b2b", 3'd3, 32'd100, 32'd7);
    check("divu_b2b_lo_const", LoOut, 32'h0000000E);

    doOp("mthi", 3'd4, 32'h12345678, 32'd0);
    doOp("div_zero", 3'd2, 32'd5, 32'd0);
    check("div_zero_hi_const", HiOut, 32'h12345678);
    @(negedge Clk);
    check("div_zero_done_pulse", {31'b0, Done}, 32'd0);
    check("div_zero_sticky", {31'b0, DivByZero}, 32'd1);

    doOp("nop", 3'd6, 32'hAAAA5555, 32'd3);

    doOp("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo_const", LoOut, 32'h80000000);

    applyStimulus(3'd1, 32'd7, 32'd6);
    modelOp(3'd1, 32'd7, 32'd6);
    waitDone(10, cycles, busyCnt);
    check("ignore_latency", cycles, 32'd34);
    checkOutput("ignore_start");
    check("ignore_lo_const", LoOut, 32'd42);

    applyStimulus(3'd0, $urandom, $urandom);
    repeat (20) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    expHi = '0; expLo = '0; expDz = 1'b0;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_done", {31'b0, Done}, 32'd0);
    checkOutput("abort");
    doOp("after_abort", 3'd1, 32'd2, 32'd3);
    check("after_abort_lo_const", LoOut, 32'd6);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = pickOperand();
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : pickOperand();
      doOp("rand", rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX pipeline register. Drives HiOut/LoOut directly into the EX-stage 32-bit 5-to-1 result-select mux as two of its data inputs, selected for MFHI/MFLO. Busy gates the hazard unit's stall so no MFHI/MFLO reads a stale value.

## Interface
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low; sampled on the Clk rising edge.
- Start  in  1  request strobe; sampled only when idle.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- A  in  WIDTH  rs operand (multiplicand/dividend/move source).
- B  in  WIDTH  rt operand (multiplier/divisor).
- Busy  out  1  high while an iterative op is in flight.
- Done  out  1  one-cycle pulse when HI/LO (or the flag) is final.
- DivByZero  out  1  sticky flag for the last accepted op.
- HiOut  out  WIDTH  HI register.
- LoOut  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX. Busy = (state != IDLE).
- IDLE, Start=1, Op MULT/MULTU/DIV/DIVU, B != 0 (or multiply):
  - Latch |A|, |B| (signed ops) or raw A, B (unsigned), plus result-sign bits.
  - Clear DivByZero. Counter := 0. Go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After WIDTH steps, go to FIX.
- FIX:
  - Apply two's-complement negation where required.
  - Write HI/LO. Go to IDLE. Assert Done next cycle.
- Multiply: 64-bit product; HI = bits 63:32, LO = bits 31:0.
- Signed multiply: negate product iff A[31]^B[31].
- Divide: LO = quotient, HI = remainder.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no flag).
- DIV/DIVU with B=0:
  - No RUN. HI/LO unchanged. DivByZero := 1 at the Start edge. Done pulses next cycle.
- MTHI/MTLO: HI (or LO) := A at the Start edge. Done pulses next cycle. Busy never asserts.
- Op 110/111: no state change and no Done.
- Start while Busy is ignored; A/B/Op changes after acceptance are ignored.
- Reset=0 at any edge, including mid-RUN or FIX, aborts the op:
  - state := IDLE; HiOut, LoOut, counter := 0.
  - Busy, Done, DivByZero := 0.

## Timing
- Reset values: HiOut=0, LoOut=0, Busy=0, Done=0, DivByZero=0.
- Iterative op, Start accepted at edge E0:
  - Busy=1 after E0 through E33.
  - HI/LO update at E33. Busy falls and Done=1 for the cycle after E33.
  - Total: 33 cycles of Busy, then results valid.
- Start may be reasserted in the Done cycle and is accepted at that edge. Back-to-back ops lose no cycle.
- MTHI/MTLO and divide-by-zero: result/flag visible after the accepting edge; Done high for exactly that following cycle.
- HiOut/LoOut are registered outputs with no combinational path from A/B. They hold their previous values throughout RUN/FIX.
- DivByZero holds until the next accepted Start or reset.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF:
  - Busy high 33 cycles, then Done.
  - HiOut=0xFFFFFFFE, LoOut=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=0x00000005: HiOut=0xFFFFFFFF, LoOut=0xFFFFFFF1.
- DIV and DIVU, back-to-back:
  - DIV A=0xFFFFFFF9 (-7), B=2: LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF.
  - DIVU A=100, B=7, started in the DIV Done cycle: LoOut=0x0000000E, HiOut=0x00000002. No idle gap.
- MTHI A=0x12345678, then DIV A=5, B=0:
  - MTHI: HiOut=0x12345678 one cycle later.
  - DIV: DivByZero=1, Done one cycle, Busy never high, HI/LO unchanged.
- MULTU 7×6 with a second Start (MTLO A=0xDEAD) at cycle 10 of RUN: second Start ignored; final LoOut=42, HiOut=0.
- MULT running, Reset=0 held one edge at cycle 20: all outputs 0 next cycle. A following MULTU 2×3 completes normally with LoOut=6.
